// File: rtl/dcf77_timekeeper.sv
// Local BCD time-of-day clock disciplined by decoded DCF77 minute frames, with holdover tracking.
// Optional calendar-date outputs are enabled by defining DCF77_DATE_EN.
module dcf77_timekeeper #(
  parameter int CLK_HZ       = 24000000,
  parameter int HOLDOVER_MIN = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [58:0] data_hold,
  input  logic        frame_stb,
  input  logic        error,
  output logic [5:0]  hh_bcd,
  output logic [6:0]  mm_bcd,
  output logic [6:0]  ss_bcd,
  output logic [2:0]  weekday,
  output logic        tick_1hz,
  output logic        synced,
  output logic        frame_rej
`ifdef DCF77_DATE_EN
  ,
  output logic [5:0]  dd_bcd,
  output logic [4:0]  mo_bcd,
  output logic [7:0]  yy_bcd
`endif
);

  localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [7:0]    HOLD_LIM = 8'(HOLDOVER_MIN);

  function automatic logic even_par_ok(input logic [22:0] bits);
    return ~(^bits);
  endfunction

  // Increment a 00..59 BCD field; wraps 59 -> 00.
  function automatic logic [6:0] inc_bcd59(input logic [6:0] v);
    if (v == 7'h59) begin
      return 7'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[6:4] + 3'd1, 4'd0};
    end else begin
      return {v[6:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [5:0] inc_bcd23(input logic [5:0] v);
    if (v == 6'h23) begin
      return 6'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[5:4] + 2'd1, 4'd0};
    end else begin
      return {v[5:4], v[3:0] + 4'd1};
    end
  endfunction

  logic [5:0]    hh_r;
  logic [6:0]    mm_r;
  logic [6:0]    ss_r;
  logic [2:0]    wd_r;
  logic          tick_r;
  logic          synced_r;
  logic          rej_r;
  logic          running_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    hold_r;

  logic [3:0] min_u_s;
  logic [2:0] min_t_s;
  logic [3:0] hr_u_s;
  logic [1:0] hr_t_s;
  logic [2:0] wd_in_s;
  logic       fields_ok_s;
  logic       accept_s;
  logic       tc_s;
  logic       ss_wrap_s;
  logic       mm_wrap_s;
  logic       hh_wrap_s;
  logic [6:0] ss_nxt_s;
  logic [6:0] mm_nxt_s;
  logic [5:0] hh_nxt_s;
  logic [2:0] wd_nxt_s;
  logic       unused_s;

`ifdef DCF77_DATE_EN
  logic [5:0] dd_r;
  logic [4:0] mo_r;
  logic [7:0] yy_r;
  logic       date_ok_s;
  assign unused_s = ^data_hold[20:0];
`else
  assign unused_s = ^{data_hold[58:45], data_hold[41:36], data_hold[20:0]};
`endif

  // Frame field decode, acceptance decision and carry-chain next values.
  always_comb begin
    min_u_s     = data_hold[24:21];
    min_t_s     = data_hold[27:25];
    hr_u_s      = data_hold[32:29];
    hr_t_s      = data_hold[34:33];
    wd_in_s     = data_hold[44:42];
    fields_ok_s = even_par_ok(23'(data_hold[28:21])) &&
                  even_par_ok(23'(data_hold[35:29])) &&
                  (min_u_s <= 4'd9) && (min_t_s <= 3'd5) && (hr_u_s <= 4'd9) &&
                  ((hr_t_s < 2'd2) || ((hr_t_s == 2'd2) && (hr_u_s <= 4'd3))) &&
                  (wd_in_s != 3'd0);
`ifdef DCF77_DATE_EN
    // Day 01..31, month 01..12, P3 covers the whole date block.
    date_ok_s = even_par_ok(data_hold[58:36]) &&
                (data_hold[39:36] <= 4'd9) && (data_hold[41:36] != 6'd0) &&
                ((data_hold[41:40] != 2'd3) || (data_hold[39:36] <= 4'd1)) &&
                (data_hold[48:45] <= 4'd9) && (data_hold[49:45] != 5'd0) &&
                ((data_hold[49] == 1'b0) || (data_hold[48:45] <= 4'd2));
    accept_s  = frame_stb && !error && fields_ok_s && date_ok_s;
`else
    accept_s  = frame_stb && !error && fields_ok_s;
`endif
    tc_s      = running_r && (presc_r == PRESC_TC);
    ss_wrap_s = (ss_r == 7'h59);
    mm_wrap_s = (mm_r == 7'h59);
    hh_wrap_s = (hh_r == 6'h23);
    ss_nxt_s  = inc_bcd59(ss_r);
    mm_nxt_s  = inc_bcd59(mm_r);
    hh_nxt_s  = inc_bcd23(hh_r);
    wd_nxt_s  = (wd_r == 3'd7) ? 3'd1 : (wd_r + 3'd1);
  end

  // Frame load, prescaler, time-of-day carry chain and holdover tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hh_r      <= 6'd0;
      mm_r      <= 7'd0;
      ss_r      <= 7'd0;
      wd_r      <= 3'd0;
      tick_r    <= 1'b0;
      synced_r  <= 1'b0;
      rej_r     <= 1'b0;
      running_r <= 1'b0;
      presc_r   <= '0;
      hold_r    <= 8'd0;
    end else begin
      rej_r  <= frame_stb && !accept_s;
      tick_r <= 1'b0;
      if (accept_s) begin
        // A load on the terminal-count cycle swallows that tick entirely.
        hh_r      <= {hr_t_s, hr_u_s};
        mm_r      <= {min_t_s, min_u_s};
        ss_r      <= 7'h00;
        wd_r      <= wd_in_s;
        presc_r   <= '0;
        hold_r    <= 8'd0;
        synced_r  <= 1'b1;
        running_r <= 1'b1;
      end else if (tc_s) begin
        presc_r <= '0;
        tick_r  <= 1'b1;
        ss_r    <= ss_nxt_s;
        if (ss_wrap_s) begin
          mm_r <= mm_nxt_s;
          if (hold_r != HOLD_LIM) begin
            hold_r <= hold_r + 8'd1;
            if ((hold_r + 8'd1) == HOLD_LIM) begin
              synced_r <= 1'b0;
            end
          end
          if (mm_wrap_s) begin
            hh_r <= hh_nxt_s;
            if (hh_wrap_s) begin
              wd_r <= wd_nxt_s;
            end
          end
        end
      end else if (running_r) begin
        presc_r <= presc_r + PW'(1);
      end else begin
        presc_r <= '0;
      end
    end
  end

`ifdef DCF77_DATE_EN
  // Date registers follow accepted frames only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dd_r <= 6'd0;
      mo_r <= 5'd0;
      yy_r <= 8'd0;
    end else if (accept_s) begin
      dd_r <= data_hold[41:36];
      mo_r <= data_hold[49:45];
      yy_r <= data_hold[57:50];
    end
  end

  assign dd_bcd = dd_r;
  assign mo_bcd = mo_r;
  assign yy_bcd = yy_r;
`endif

  assign hh_bcd    = hh_r;
  assign mm_bcd    = mm_r;
  assign ss_bcd    = ss_r;
  assign weekday   = wd_r;
  assign tick_1hz  = tick_r;
  assign synced    = synced_r;
  assign frame_rej = rej_r;

endmodule

// File: tb/tb_dcf77_timekeeper.sv
// Randomized bench for dcf77_timekeeper: time is modelled as seconds-of-day plus weekday,
// compared against the DUT every cycle, with literal checks pinning key scenarios.
module tb_dcf77_timekeeper;
  localparam int CLK_HZ = 10;
  localparam int HOLD   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [58:0] data_hold = '0;
  logic        frame_stb = 1'b0;
  logic        error = 1'b0;
  logic [5:0]  hh_bcd;
  logic [6:0]  mm_bcd;
  logic [6:0]  ss_bcd;
  logic [2:0]  weekday;
  logic        tick_1hz;
  logic        synced;
  logic        frame_rej;

  dcf77_timekeeper #(.CLK_HZ(CLK_HZ), .HOLDOVER_MIN(HOLD)) dut (
    .clk(clk), .rst(rst), .data_hold(data_hold), .frame_stb(frame_stb), .error(error),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd), .weekday(weekday),
    .tick_1hz(tick_1hz), .synced(synced), .frame_rej(frame_rej)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int bcd(input int n);
    return (n / 10) * 16 + (n % 10);
  endfunction

  // What the generator intended the frame on data_hold to mean.
  bit gen_valid = 1'b0;
  int gen_secs  = 0;
  int gen_wd    = 0;

  // Reference state: seconds since midnight, weekday, cycles since last second boundary.
  int m_secs = 0, m_wd = 0, m_phase = 0, m_mins = 0;
  bit m_run = 0, m_sync = 0, m_tick = 0, m_rej = 0;

  always @(posedge clk or negedge rst) begin : model
    int s, w, p, mi;
    bit ru, sy, tk, rj;
    if (!rst) begin
      m_secs <= 0; m_wd <= 0; m_phase <= 0; m_mins <= 0;
      m_run <= 0; m_sync <= 0; m_tick <= 0; m_rej <= 0;
    end else begin
      s = m_secs; w = m_wd; p = m_phase; mi = m_mins; ru = m_run; sy = m_sync;
      tk = 0; rj = 0;
      if (frame_stb && gen_valid) begin
        s = gen_secs; w = gen_wd; p = 0; mi = 0; sy = 1; ru = 1;
      end else begin
        if (frame_stb) rj = 1;
        if (ru) begin
          if (p == CLK_HZ - 1) begin
            p = 0; tk = 1; s = s + 1;
            if (s == 86400) begin
              s = 0;
              w = (w == 7) ? 1 : w + 1;
            end
            if (s % 60 == 0) begin
              if (mi < HOLD) mi = mi + 1;
              if (mi == HOLD) sy = 0;
            end
          end else begin
            p = p + 1;
          end
        end
      end
      m_secs <= s; m_wd <= w; m_phase <= p; m_mins <= mi;
      m_run <= ru; m_sync <= sy; m_tick <= tk; m_rej <= rj;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hh", int'(hh_bcd), bcd(m_secs / 3600));
      check("mm", int'(mm_bcd), bcd((m_secs / 60) % 60));
      check("ss", int'(ss_bcd), bcd(m_secs % 60));
      check("weekday", int'(weekday), m_wd);
      check("tick_1hz", int'(tick_1hz), int'(m_tick));
      check("synced", int'(synced), int'(m_sync));
      check("frame_rej", int'(frame_rej), int'(m_rej));
    end
  end

  // Drive one frame for one cycle; returns at the negedge where its effect is visible.
  task automatic send(input int mu, input int mt, input int hu, input int ht, input int wd,
                      input bit f1, input bit f2, input bit err);
    logic [58:0] f;
    f = 59'({$urandom(), $urandom()});
    f[24:21] = mu[3:0];
    f[27:25] = mt[2:0];
    f[32:29] = hu[3:0];
    f[34:33] = ht[1:0];
    f[44:42] = wd[2:0];
    f[28] = (^f[27:21]) ^ f1;
    f[35] = (^f[34:29]) ^ f2;
    @(negedge clk);
    data_hold = f;
    frame_stb = 1'b1;
    error     = err;
    gen_valid = !err && !f1 && !f2 && mu <= 9 && mt <= 5 && hu <= 9 &&
                (ht * 10 + hu) <= 23 && wd != 0;
    gen_secs  = (ht * 10 + hu) * 3600 + (mt * 10 + mu) * 60;
    gen_wd    = wd;
    @(negedge clk);
    frame_stb = 1'b0;
    error     = 1'b0;
  endtask

  task automatic load(input int hh, input int mm, input int wd);
    send(mm % 10, mm / 10, hh % 10, hh / 10, wd, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: nothing runs without a frame.
    repeat (100) @(negedge clk);
    check("idle_all_zero", int'({hh_bcd, mm_bcd, ss_bcd, weekday, tick_1hz, synced, frame_rej}), 0);

    // 12:34, Wednesday.
    load(12, 34, 3);
    check("load_hh", int'(hh_bcd), 'h12);
    check("load_mm", int'(mm_bcd), 'h34);
    check("load_ss", int'(ss_bcd), 'h00);
    check("load_synced", int'(synced), 1);
    repeat (9) @(negedge clk);
    check("pre_tick", int'(tick_1hz), 0);
    @(negedge clk);
    check("first_tick", int'(tick_1hz), 1);
    check("first_ss", int'(ss_bcd), 'h01);

    // Rejections: P1 flipped, decoder error, hour 24, weekday 0.
    send(4, 3, 2, 1, 3, 1'b1, 1'b0, 1'b0);
    check("rej_p1", int'(frame_rej), 1);
    check("rej_p1_hh", int'(hh_bcd), 'h12);
    send(0, 1, 5, 0, 2, 1'b0, 1'b0, 1'b1);
    check("rej_err", int'(frame_rej), 1);
    send(0, 0, 4, 2, 2, 1'b0, 1'b0, 1'b0);
    check("rej_h24", int'(frame_rej), 1);
    check("rej_h24_synced", int'(synced), 1);
    send(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    check("rej_wd0", int'(frame_rej), 1);

    // Midnight rollover on Sunday, then holdover expiry at the second minute wrap.
    load(23, 59, 7);
    repeat (599) @(negedge clk);
    check("pre_mid_time", int'({hh_bcd, mm_bcd, ss_bcd}), int'({6'h23, 7'h59, 7'h59}));
    @(negedge clk);
    check("mid_time", int'({hh_bcd, mm_bcd, ss_bcd}), 0);
    check("mid_wd", int'(weekday), 1);
    check("mid_synced", int'(synced), 1);
    repeat (599) @(negedge clk);
    check("hold_pre", int'(synced), 1);
    @(negedge clk);
    check("hold_drop", int'(synced), 0);
    check("hold_mm", int'(mm_bcd), 'h01);

    // Frame coincident with prescaler terminal count.
    load(8, 15, 2);
    repeat (8) @(negedge clk);
    send(2, 4, 0, 1, 5, 1'b0, 1'b0, 1'b0);
    check("coin_tick", int'(tick_1hz), 0);
    check("coin_time", int'({hh_bcd, mm_bcd, ss_bcd}), int'({6'h10, 7'h42, 7'h00}));
    repeat (9) @(negedge clk);
    check("coin_no_early_tick", int'(tick_1hz), 0);
    @(negedge clk);
    check("coin_next_tick", int'({tick_1hz, ss_bcd}), int'({1'b1, 7'h01}));

    // Random frames with random gaps.
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        load($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(1, 7));
      end else begin
        send($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15),
             $urandom_range(0, 3), $urandom_range(0, 7),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0));
      end
    end

    // Asynchronous reset mid-operation.
    load(17, 5, 4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", int'({hh_bcd, mm_bcd, ss_bcd, weekday, tick_1hz, synced, frame_rej}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", int'({hh_bcd, mm_bcd, ss_bcd, weekday, synced}), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dcf77_timekeeper.md
Name: dcf77_timekeeper

Overview:
Downstream consumer of the dcf77 decoder. On each decoded minute frame it checks parity and BCD ranges, then loads a local BCD time-of-day clock (hh:mm:ss plus weekday). Between frames it free-runs from a clk-derived 1 Hz prescaler. It reports sync status and holdover loss to the display logic and board LEDs.

Parameters:
CLK_HZ, 24000000, clk frequency; prescaler terminal count is CLK_HZ-1.
HOLDOVER_MIN, 10, minutes without a valid frame before synced drops (1..255).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
data_hold  input  59  decoded DCF77 frame, bit n = second n of the frame
frame_stb  input  1  one-cycle pulse; data_hold and error are valid this cycle (minute mark)
error  input  1  decoder frame error, sampled with frame_stb
hh_bcd  output  6  hours: [5:4] tens, [3:0] units
mm_bcd  output  7  minutes: [6:4] tens, [3:0] units
ss_bcd  output  7  seconds: [6:4] tens, [3:0] units
weekday  output  3  1=Mon..7=Sun; 0 = unknown
tick_1hz  output  1  one-cycle pulse on each local second increment
synced  output  1  1 = valid frame loaded within the last HOLDOVER_MIN minutes
frame_rej  output  1  one-cycle pulse when a frame_stb is rejected

Behaviour:
- Reset (rst=0, async): hh/mm/ss=0, weekday=0, tick_1hz=0, synced=0, frame_rej=0, prescaler=0, holdover counter=0. Clock does not run until the first valid frame.
- Frame fields:
  - Minute units [24:21], minute tens [27:25], P1 [28]: even parity over [28:21].
  - Hour units [32:29], hour tens [34:33], P2 [35]: even parity over [35:29].
  - Weekday [44:42].
- Frame accepted iff frame_stb=1, error=0, P1 ok, P2 ok, minute units<=9, minute tens<=5, hour units<=9, hours<=23, weekday!=0.
- Accept, registered, visible the cycle after frame_stb:
  - hh/mm/weekday loaded, ss=00.
  - Prescaler cleared to 0, holdover counter cleared, synced=1.
  - No tick_1hz this cycle.
- Reject: frame_rej pulses one cycle after frame_stb; time, prescaler and synced are unchanged.
- Prescaler: runs only after the first accept. It counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0 and tick_1hz pulses with the ss increment.
- Carry chain, all in the same cycle:
  - ss 59 -> 00 carries to mm.
  - mm 59 -> 00 carries to hh.
  - hh 23 -> 00 advances weekday 7 -> 1, else +1.
  - The BCD units digit wraps 9 -> 0 with a tens increment.
- Holdover: a saturating counter increments on each ss 59->00 wrap. When it reaches HOLDOVER_MIN, synced goes to 0. Time keeps running.
- Simultaneous frame_stb and prescaler terminal count: the load wins, the tick is suppressed, and no increment occurs.
- Leap second: no special handling; the next frame realigns ss.
- Reset asserted mid-operation: everything returns to reset values immediately.

Optional Feature:
DCF77_DATE_EN.
- Defined: adds outputs dd_bcd[5:0] ([41:36]), mo_bcd[4:0] ([49:45]) and yy_bcd[7:0] ([57:50]).
  - Accept additionally requires even parity over [58:36], day 01..31 and month 01..12.
  - The date is loaded on accept and reset to 0.
  - It is not advanced by the local clock; it holds until the next frame.
- Undefined: date bits and P3 are ignored, and the ports are absent.

Test Plan:
- CLK_HZ=10. Release reset; apply no frame for 100 cycles -> all outputs 0, no tick_1hz.
- Frame 12:34 (mm=0x34, hh=0x12), weekday 3, valid parity, error=0 -> next cycle hh=0x12, mm=0x34, ss=0x00, synced=1; ss=0x01 and tick_1hz after 10 cycles.
- Load 23:59, weekday 7; run 60 s -> hh=0x00, mm=0x00, ss=0x00, weekday=1 in one cycle.
- Valid frame except P1 flipped, or error=1, or hours=24 -> frame_rej pulse; time unchanged, synced unchanged.
- HOLDOVER_MIN=2: after accept, no frames for 2 minute wraps -> synced 1->0 exactly at the second ss 59->00; time continues.
- frame_stb coincident with prescaler terminal count -> loaded time with ss=0x00, no tick_1hz; the next tick follows 10 cycles later.
